// File: rtl/display_scheduler.sv
`default_nettype none
// display_scheduler: shares one 4-digit display among four requesters using round-robin
// arbitration, a tick-based minimum hold time and a one-cycle blank gap on every hand-off.
module display_scheduler #(
   parameter int unsigned PRESCALE   = 100000,
   parameter int unsigned HOLD_TICKS = 500,
   parameter logic [15:0] IDLE_VALUE = 16'h0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  req,
   input  logic [63:0] req_data,
   output logic [3:0]  grant,
   output logic [1:0]  disp_src,
   output logic [15:0] disp_value,
   output logic        disp_valid,
   output logic        tick
);

   localparam int PW = $clog2(PRESCALE);
   localparam int HW = $clog2(HOLD_TICKS + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SHOW = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] pre_q, pre_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [1:0]    last_q, last_d;
   logic [1:0]    src_q, src_d;
   logic [3:0]    grant_q, grant_d;
   logic [15:0]   value_q, value_d;
   logic          valid_q, valid_d;

   logic          tick_now;
   logic          hold_done;
   logic          other_req;
   logic          win_found;
   logic [1:0]    win_idx;
   logic [1:0]    cand;

   assign tick_now  = (pre_q == PW'(PRESCALE - 1));
   assign hold_done = (hold_q == HW'(HOLD_TICKS));
   assign other_req = |(req & ~grant_q);

   // Search starts one past the last winner, so every source gets its turn.
   always_comb begin
      win_found = 1'b0;
      win_idx   = 2'd0;
      cand      = 2'd0;
      for (int k = 1; k <= 4; k++) begin
         cand = last_q + 2'(k);
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_comb begin
      pre_d   = tick_now ? '0 : pre_q + PW'(1);
      state_d = state_q;
      hold_d  = hold_q;
      last_d  = last_q;
      src_d   = src_q;
      grant_d = grant_q;
      value_d = value_q;
      valid_d = valid_q;

      case (state_q)
         ST_IDLE, ST_GAP: begin
            if (win_found) begin
               state_d = ST_SHOW;
               hold_d  = '0;
               last_d  = win_idx;
               src_d   = win_idx;
               grant_d = 4'b0001 << win_idx;
               value_d = req_data[{win_idx, 4'b0000} +: 16];
               valid_d = 1'b1;
            end else begin
               state_d = ST_IDLE;
               grant_d = 4'b0000;
               value_d = IDLE_VALUE;
               valid_d = 1'b0;
            end
         end
         ST_SHOW: begin
            if (!req[src_q] || (hold_done && other_req)) begin
               state_d = ST_GAP;
               grant_d = 4'b0000;
               value_d = IDLE_VALUE;
               valid_d = 1'b0;
            end else begin
               value_d = req_data[{src_q, 4'b0000} +: 16];
               if (tick_now && !hold_done) begin
                  hold_d = hold_q + HW'(1);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = 4'b0000;
            value_d = IDLE_VALUE;
            valid_d = 1'b0;
         end
      endcase
   end

   // last_q resets to 3 so that source 0 leads the first search after reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         pre_q   <= '0;
         hold_q  <= '0;
         last_q  <= 2'd3;
         src_q   <= 2'd0;
         grant_q <= 4'b0000;
         value_q <= IDLE_VALUE;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         hold_q  <= hold_d;
         last_q  <= last_d;
         src_q   <= src_d;
         grant_q <= grant_d;
         value_q <= value_d;
         valid_q <= valid_d;
      end
   end

   assign grant      = grant_q;
   assign disp_src   = src_q;
   assign disp_value = value_q;
   assign disp_valid = valid_q;
   assign tick       = tick_now;

endmodule

`default_nettype wire

// File: tb/tb_display_scheduler.sv
`default_nettype none
// tb_display_scheduler: directed scenarios; a monitor pops the expected display state
// (and how many cycles it must persist) every time the DUT outputs change.
module tb_display_scheduler;

   logic        clk;
   logic        reset;
   logic [3:0]  req;
   logic [63:0] req_data;
   logic [3:0]  grant;
   logic [1:0]  disp_src;
   logic [15:0] disp_value;
   logic        disp_valid;
   logic        tick;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [3:0]  g;
      logic [1:0]  s;
      logic [15:0] v;
      logic        dv;
      int          len;
   } exp_t;

   exp_t exp_q[$];

   display_scheduler #(
      .PRESCALE   (4),
      .HOLD_TICKS (2),
      .IDLE_VALUE (16'hFFFF)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .req_data   (req_data),
      .grant      (grant),
      .disp_src   (disp_src),
      .disp_value (disp_value),
      .disp_valid (disp_valid),
      .tick       (tick)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   // len = number of sampled cycles the state must persist; 0 = not checked
   function automatic void push(input logic [3:0] g, input logic [1:0] s,
                                input logic [15:0] v, input logic dv, input int len);
      exp_t e;
      e.g   = g;
      e.s   = s;
      e.v   = v;
      e.dv  = dv;
      e.len = len;
      exp_q.push_back(e);
   endfunction

   task automatic do_reset(input logic [3:0] r);
      reset = 1'b0;
      req   = r;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
   endtask

   // Monitor
   initial begin
      logic [22:0] prev_t;
      logic [22:0] cur_t;
      bit          have_prev;
      bit          cur_ok;
      exp_t        cur_e;
      int          ncyc;
      int          start_cyc;
      have_prev = 1'b0;
      cur_ok    = 1'b0;
      ncyc      = 0;
      start_cyc = 0;
      prev_t    = '0;
      forever begin
         @(negedge clk);
         ncyc++;
         cur_t = {grant, disp_src, disp_value, disp_valid};
         if (!have_prev || cur_t != prev_t) begin
            if (cur_ok && cur_e.len != 0)
               chk("state_length", 32'(ncyc - start_cyc), 32'(cur_e.len));
            if (exp_q.size() == 0) begin
               chk("unexpected_change", 32'(cur_t), 32'hFFFF_FFFF);
               cur_ok = 1'b0;
            end else begin
               cur_e  = exp_q.pop_front();
               cur_ok = 1'b1;
               chk("grant_src_value_valid", 32'(cur_t),
                   32'({cur_e.g, cur_e.s, cur_e.v, cur_e.dv}));
            end
            start_cyc = ncyc;
            prev_t    = cur_t;
            have_prev = 1'b1;
         end
      end
   end

   initial begin
      reset    = 1'b1;
      req      = 4'b1111;
      req_data = {16'hA333, 16'hA222, 16'hA111, 16'hA000};
      push(4'b0000, 2'd0, 16'hFFFF, 1'b0, 0);
      #1 reset = 1'b0;

      // Reset held with all requests active
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("rst_grant", 32'(grant), 32'h0);
         chk("rst_valid", 32'(disp_valid), 32'h0);
         chk("rst_value", 32'(disp_value), 32'hFFFF);
         chk("rst_tick", 32'(tick), 32'h0);
      end

      // Round-robin with all four requesting
      push(4'b0001, 2'd0, 16'hA000, 1'b1, 8);
      push(4'b0000, 2'd0, 16'hFFFF, 1'b0, 1);
      push(4'b0010, 2'd1, 16'hA111, 1'b1, 7);
      push(4'b0000, 2'd1, 16'hFFFF, 1'b0, 1);
      push(4'b0100, 2'd2, 16'hA222, 1'b1, 7);
      push(4'b0000, 2'd2, 16'hFFFF, 1'b0, 1);
      push(4'b1000, 2'd3, 16'hA333, 1'b1, 7);
      push(4'b0000, 2'd3, 16'hFFFF, 1'b0, 1);
      push(4'b0001, 2'd0, 16'hA000, 1'b1, 2);
      push(4'b0000, 2'd0, 16'hFFFF, 1'b0, 0);
      @(posedge clk);
      #1 reset = 1'b1;
      for (int c = 1; c <= 35; c++) begin
         @(negedge clk);
         chk("tick_phase", 32'(tick), 32'((c % 4) == 0));
      end
      @(posedge clk);
      #1 req = 4'b0000;
      repeat (4) @(posedge clk);

      // Single source, data follows with one cycle of latency
      req_data[47:32] = 16'h1234;
      push(4'b0100, 2'd2, 16'h1234, 1'b1, 3);
      push(4'b0100, 2'd2, 16'hBEEF, 1'b1, 3);
      push(4'b0000, 2'd2, 16'hFFFF, 1'b0, 0);
      do_reset(4'b0100);
      repeat (3) @(posedge clk);
      #1 req_data[47:32] = 16'hBEEF;
      repeat (3) @(posedge clk);
      #1 req = 4'b0000;
      repeat (4) @(posedge clk);
      req_data[47:32] = 16'hA222;

      // Hold: source 1 waits for source 0's minimum hold
      push(4'b0000, 2'd0, 16'hFFFF, 1'b0, 0);
      push(4'b0001, 2'd0, 16'hA000, 1'b1, 8);
      push(4'b0000, 2'd0, 16'hFFFF, 1'b0, 1);
      push(4'b0010, 2'd1, 16'hA111, 1'b1, 2);
      push(4'b0000, 2'd1, 16'hFFFF, 1'b0, 0);
      do_reset(4'b0001);
      @(posedge clk);
      #1 req = 4'b0011;
      repeat (10) @(posedge clk);
      #1 req = 4'b0000;
      repeat (4) @(posedge clk);

      // Early drop hands over to source 3 after one gap cycle
      push(4'b0000, 2'd0, 16'hFFFF, 1'b0, 0);
      push(4'b0001, 2'd0, 16'hA000, 1'b1, 1);
      push(4'b0000, 2'd0, 16'hFFFF, 1'b0, 1);
      push(4'b1000, 2'd3, 16'hA333, 1'b1, 2);
      push(4'b0000, 2'd3, 16'hFFFF, 1'b0, 0);
      do_reset(4'b1001);
      @(posedge clk);
      #1 req = 4'b1000;
      repeat (3) @(posedge clk);
      #1 req = 4'b0000;
      repeat (4) @(posedge clk);

      // Reset in the middle of a grant
      push(4'b0000, 2'd0, 16'hFFFF, 1'b0, 0);
      push(4'b0100, 2'd2, 16'hA222, 1'b1, 1);
      push(4'b0000, 2'd0, 16'hFFFF, 1'b0, 0);
      push(4'b0010, 2'd1, 16'hA111, 1'b1, 2);
      push(4'b0000, 2'd1, 16'hFFFF, 1'b0, 0);
      do_reset(4'b0100);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      chk("async_rst_grant", 32'(grant), 32'h0);
      chk("async_rst_value", 32'(disp_value), 32'hFFFF);
      req = 4'b0110;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 req = 4'b0000;
      repeat (6) @(posedge clk);

      chk("expected_queue_drained", 32'(exp_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/display_scheduler.md
DISPLAY_SCHEDULER -- requirements
Module: display_scheduler

Interface
REQ-001 The block SHALL have parameter PRESCALE, default 100000, meaning clk cycles per display tick; legal values are 2 or more.
REQ-002 The block SHALL have parameter HOLD_TICKS, default 500, meaning the minimum ticks a granted source owns the display; legal values are 1 or more.
REQ-003 The block SHALL have parameter IDLE_VALUE, default 16'h0000, meaning the value shown when no source is granted.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-006 The block SHALL have port req, input, 4 bits: per-source display request, level-sensitive.
REQ-007 The block SHALL have port req_data, input, 64 bits: source i value on bits [16i+15:16i].
REQ-008 The block SHALL have port grant, output, 4 bits: one-hot or zero, registered.
REQ-009 The block SHALL have port disp_src, output, 2 bits: index of the granted source, registered.
REQ-010 The block SHALL have port disp_value, output, 16 bits: value for the 4-digit display, registered.
REQ-011 The block SHALL have port disp_valid, output, 1 bit: high while any grant is high.
REQ-012 The block SHALL have port tick, output, 1 bit: a one-cycle strobe every PRESCALE cycles.

Function
REQ-013 The prescaler SHALL count 0..PRESCALE-1, wrapping to 0, and tick SHALL be high for the cycle in which the count equals PRESCALE-1.
REQ-014 The FSM SHALL have exactly three states: IDLE, SHOW and GAP.
REQ-015 IDLE: grant=0, disp_valid=0 and disp_value=IDLE_VALUE; if any req bit is high, the FSM SHALL enter SHOW on the next edge with the arbitration winner granted.
REQ-016 Arbitration SHALL be round-robin, with priority starting at (last_src+1) mod 4 and ascending with wrap; last_src SHALL update to the winner on each grant.
REQ-017 On entry to SHOW: grant[w]=1, disp_src=w, disp_valid=1, hold_cnt=0, and disp_value=req_data of w sampled at that same edge.
REQ-018 In SHOW, disp_value SHALL reload from the granted source's req_data every cycle, giving one cycle of latency.
REQ-019 In SHOW, hold_cnt SHALL increment on each tick and saturate at HOLD_TICKS; hold_done means hold_cnt==HOLD_TICKS.
REQ-020 SHOW SHALL release when req[disp_src]==0, regardless of hold_done.
REQ-021 SHOW SHALL also release when hold_done is true and any other req bit is high.
REQ-022 If hold_done is true, the current req is high and no other req is high, the FSM SHALL remain in SHOW.
REQ-023 On release, the FSM SHALL enter GAP for exactly one cycle with grant=0, disp_valid=0 and disp_value=IDLE_VALUE; this makes every hand-off break-before-make.
REQ-024 GAP SHALL go to SHOW with the arbitration winner if any req bit is high; otherwise it SHALL go to IDLE.
REQ-025 A tick coinciding with release or GAP SHALL have no effect, and hold_cnt SHALL restart at 0 for each new grant.
REQ-026 disp_src SHALL retain its last value in IDLE and GAP.
REQ-027 hold_cnt width SHALL be clog2(HOLD_TICKS+1), and the prescaler width SHALL be clog2(PRESCALE).

Reset
REQ-028 While reset=0, the block SHALL asynchronously force state=IDLE, grant=0, disp_src=0, disp_valid=0, disp_value=IDLE_VALUE, tick=0, prescaler=0, hold_cnt=0 and last_src=3, so that source 0 has top priority after reset.
REQ-029 A reset asserted mid-SHOW SHALL drop grant immediately, without waiting for a clock edge.
REQ-030 After reset deasserts, the block SHALL behave identically to post power-up.

Verification (PRESCALE=4, HOLD_TICKS=2, IDLE_VALUE=16'hFFFF)
REQ-031 Reset: hold reset=0 with req=4'b1111 -> grant=0, disp_valid=0, disp_value=FFFF and tick=0 throughout; after release, tick pulses on cycles 4, 8, 12 and so on, one cycle wide.
REQ-032 Single source: req=4'b0100 with data2=16'h1234 from IDLE -> next edge grant=0100, disp_src=2, disp_value=1234; change data2 to 16'hBEEF -> disp_value=BEEF one cycle later; drop req2 -> next edge GAP (grant=0, FFFF), then IDLE.
REQ-033 Round-robin: req=4'b1111 held after reset -> grants in order 0001, 0010, 0100, 1000, 0001; each grant lasts until the second tick after its grant, and each hand-off has exactly one GAP cycle.
REQ-034 Hold: req0 granted, then req1 raised one cycle later -> grant0 persists until hold_cnt reaches 2, then one GAP cycle, then grant=0010.
REQ-035 Early drop: req0 granted, req0 dropped before the first tick while req3 is high -> next edge GAP, then grant=1000.
REQ-036 Mid-operation reset: reset=0 while grant=0100 -> grant=0 and disp_value=FFFF with no clock edge; on release with req=4'b0110 -> grant=0010 next edge, because source 0 is highest priority and the first requesting source is 1.
